// File: rtl/uart_rx_if.sv
// Serial receive side bundle: line and baud tick in, received byte and frame status out.
// Driver side uses master, the receiver uses slave.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 b_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] d_out;
   logic                 rx_done;
   logic                 rx_busy;
   logic                 frame_err;

   modport master (
      output b_tick, rx,
      input  d_out, rx_done, rx_busy, frame_err
   );

   modport slave (
      input  b_tick, rx,
      output d_out, rx_done, rx_busy, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver at 16x oversampling; byte and rx_done appear at the stop-bit centre.
// No backpressure: d_out is overwritten by each completed frame, the consumer must take it on rx_done.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SB_TICK   = 16,
   parameter int SYNC_STG  = 2
) (
   input logic       clk,
   input logic       resetn,
   uart_rx_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam int             BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [3:0]     SB_LAST  = 4'(SB_TICK - 1);

   logic [SYNC_STG-1:0]  sync_q,  sync_d;
   logic [1:0]           state_q, state_d;
   logic [3:0]           tick_q,  tick_d;
   logic [BW-1:0]        bit_q,   bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] dout_q,  dout_d;
   logic                 done_q,  done_d;
   logic                 busy_q,  busy_d;
   logic                 ferr_q,  ferr_d;
   logic                 rx_s;

   always_comb begin
      sync_d  = {sync_q[SYNC_STG-2:0], bus.rx};
      rx_s    = sync_q[SYNC_STG-1];
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               tick_d  = 4'd0;
            end
         end
         S_START: begin
            // Start must still be low at its centre, otherwise it was a glitch.
            if (bus.b_tick) begin
               if (tick_q == 4'd7) begin
                  if (!rx_s) begin
                     state_d = S_DATA;
                     tick_d  = 4'd0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (bus.b_tick) begin
               if (tick_q == 4'd15) begin
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  tick_d  = 4'd0;
                  if (bit_q == BIT_LAST) begin
                     state_d = S_STOP;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         S_STOP: begin
            // Finishing at the stop centre leaves half a bit to re-arm for the next start.
            if (bus.b_tick) begin
               if (tick_q == SB_LAST) begin
                  dout_d  = shreg_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= '1;
         state_q <= S_IDLE;
         tick_q  <= 4'd0;
         bit_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.d_out     = dout_q;
   assign bus.rx_done   = done_q;
   assign bus.rx_busy   = busy_q;
   assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged 8N1 frames on a 1-in-4-clock b_tick.
module tb_uart_rx;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_errors;
   int   done_cnt;
   int   tick_div;
   logic [7:0] log_b[$];

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(.DATA_BITS(8), .SB_TICK(16), .SYNC_STG(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // b_tick: one clock high in every four, changed on the falling edge
   initial begin
      tick_div   = 0;
      bus.b_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div   = (tick_div + 1) % 4;
         bus.b_tick = (tick_div == 0);
      end
   end

   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         log_b.push_back(bus.d_out);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (bus.b_tick !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic send_bit(input logic v, input int ticks);
      @(negedge clk);
      bus.rx = v;
      wait_ticks(ticks);
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) send_bit(b[i], 16);
      send_bit(1'b1, 16);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      done_cnt = 0;
      bus.rx   = 1'b1;
      resetn   = 1'b0;

      // Reset values with an idle line
      repeat (3) @(negedge clk);
      check("rst_d_out",     32'(bus.d_out),     32'h00);
      check("rst_rx_done",   32'(bus.rx_done),   32'h0);
      check("rst_rx_busy",   32'(bus.rx_busy),   32'h0);
      check("rst_frame_err", 32'(bus.frame_err), 32'h0);
      resetn = 1'b1;
      wait_ticks(4);

      // Single frame 0xA5
      send_frame(8'hA5);
      @(negedge clk);
      check("a5_done_cnt",  32'(done_cnt),      32'd1);
      check("a5_log",       32'(log_b[0]),      32'hA5);
      check("a5_d_out",     32'(bus.d_out),     32'hA5);
      check("a5_frame_err", 32'(bus.frame_err), 32'h0);
      check("a5_busy_low",  32'(bus.rx_busy),   32'h0);

      // Back-to-back frames, no idle gap
      send_frame(8'h00);
      send_frame(8'hFF);
      send_frame(8'h55);
      @(negedge clk);
      check("b2b_done_cnt", 32'(done_cnt),  32'd4);
      check("b2b_byte0",    32'(log_b[1]),  32'h00);
      check("b2b_byte1",    32'(log_b[2]),  32'hFF);
      check("b2b_byte2",    32'(log_b[3]),  32'h55);
      check("b2b_ferr",     32'(bus.frame_err), 32'h0);

      // Glitch shorter than half a bit is rejected
      @(negedge clk);
      bus.rx = 1'b0;
      wait_ticks(4);
      @(negedge clk);
      check("glitch_busy_hi", 32'(bus.rx_busy), 32'h1);
      bus.rx = 1'b1;
      wait_ticks(12);
      @(negedge clk);
      check("glitch_busy_lo",  32'(bus.rx_busy), 32'h0);
      check("glitch_done_cnt", 32'(done_cnt),    32'd4);
      check("glitch_d_out",    32'(bus.d_out),   32'h55);

      // Framing error: 0x3C with stop bit held low past its centre
      send_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) send_bit(8'h3C >> i, 16);
      send_bit(1'b0, 12);
      send_bit(1'b1, 20);
      @(negedge clk);
      check("ferr_done_cnt", 32'(done_cnt),      32'd5);
      check("ferr_d_out",    32'(bus.d_out),     32'h3C);
      check("ferr_flag",     32'(bus.frame_err), 32'h1);
      check("ferr_busy_lo",  32'(bus.rx_busy),   32'h0);

      // Good frame clears the error flag
      send_frame(8'h3C);
      @(negedge clk);
      check("good_done_cnt", 32'(done_cnt),      32'd6);
      check("good_d_out",    32'(bus.d_out),     32'h3C);
      check("good_ferr",     32'(bus.frame_err), 32'h0);

      // Reset after the third data bit of 0x81
      send_bit(1'b0, 16);
      send_bit(1'b1, 16);
      send_bit(1'b0, 16);
      send_bit(1'b0, 16);
      @(negedge clk);
      check("mid_busy_hi", 32'(bus.rx_busy), 32'h1);
      resetn = 1'b0;
      bus.rx = 1'b1;
      @(negedge clk);
      check("mid_rst_d_out",     32'(bus.d_out),     32'h00);
      check("mid_rst_rx_done",   32'(bus.rx_done),   32'h0);
      check("mid_rst_rx_busy",   32'(bus.rx_busy),   32'h0);
      check("mid_rst_frame_err", 32'(bus.frame_err), 32'h0);
      check("mid_rst_done_cnt",  32'(done_cnt),      32'd6);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      wait_ticks(4);

      send_frame(8'h81);
      @(negedge clk);
      check("post_done_cnt", 32'(done_cnt),      32'd7);
      check("post_d_out",    32'(bus.d_out),     32'h81);
      check("post_ferr",     32'(bus.frame_err), 32'h0);
      check("post_busy_lo",  32'(bus.rx_busy),   32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
